// File: rtl/race_ctrl_multi_if.sv
// ---------------------------------------------------------------------------
// race_ctrl_multi_if
// Purpose : bundles the race sequencer's control inputs (race enable, per-car
//           buttons, frame tick, datapath completion strobes) and its
//           drawing-datapath request outputs into one connection.
// Modports:
//   master - the sequencer: consumes buttons/frame/done strobes, drives
//            draw_bg/draw_car/clear, car_sel/car_lane/car_pos, resetsignal,
//            race_done and winner.
//   slave  - the surrounding system (input synchroniser + VGA datapath).
// Signals :
//   start          race enable level (0 aborts to the reset sequence)
//   straight[N]    per-car forward request level
//   left/right[N]  per-car lane buttons, rising-edge significant
//   oneframe       one-cycle pulse per video frame
//   done_bg/done_car/done_clear   datapath completion strobes
//   draw_bg/draw_car/clear        datapath requests
//   car_sel/car_lane/car_pos      car addressed by draw_car/clear and its place
//   resetsignal    datapath reset strobe
//   race_done/winner              race result
// ---------------------------------------------------------------------------
interface race_ctrl_multi_if #(
  parameter int NUM_CARS  = 2,
  parameter int NUM_LANES = 4,
  parameter int TRACK_LEN = 16
);
  localparam int CW = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam int LW = $clog2(NUM_LANES);
  localparam int PW = $clog2(TRACK_LEN);

  logic                start;
  logic [NUM_CARS-1:0] straight;
  logic [NUM_CARS-1:0] left;
  logic [NUM_CARS-1:0] right;
  logic                oneframe;
  logic                done_bg;
  logic                done_car;
  logic                done_clear;

  logic                draw_bg;
  logic                draw_car;
  logic                clear;
  logic [CW-1:0]       car_sel;
  logic [LW-1:0]       car_lane;
  logic [PW-1:0]       car_pos;
  logic                resetsignal;
  logic                race_done;
  logic [CW-1:0]       winner;

  modport master (
    input  start, straight, left, right, oneframe, done_bg, done_car, done_clear,
    output draw_bg, draw_car, clear, car_sel, car_lane, car_pos, resetsignal,
           race_done, winner
  );

  modport slave (
    output start, straight, left, right, oneframe, done_bg, done_car, done_clear,
    input  draw_bg, draw_car, clear, car_sel, car_lane, car_pos, resetsignal,
           race_done, winner
  );
endinterface

// File: rtl/race_ctrl_multi.sv
// ---------------------------------------------------------------------------
// race_ctrl_multi
// Purpose : game sequencer for the multi-car racing mode. Drives the
//           background / car draw and car clear handshakes towards the VGA
//           datapath, applies per-car lane changes and forward steps on frame
//           ticks, keeps lane / track position / lap count per car and
//           declares the first car to complete LAPS laps as the winner.
// Ports   :
//   clock  - system clock, all state on the rising edge
//   reset  - asynchronous, active-high; forces the reset sequence
//   bus    - race_ctrl_multi_if.master (buttons, frame tick, datapath
//            handshakes and race result)
// Outputs are registered copies of the decoded next state, so every output
// is a pure function of state registers with no input-to-output path.
// ---------------------------------------------------------------------------
module race_ctrl_multi #(
  parameter int NUM_CARS  = 2,
  parameter int NUM_LANES = 4,
  parameter int TRACK_LEN = 16,
  parameter int LAPS      = 3,
  parameter int FRAME_DIV = 4
) (
  input  logic              clock,
  input  logic              reset,
  race_ctrl_multi_if.master bus
);
  localparam int CW = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam int LW = $clog2(NUM_LANES);
  localparam int PW = $clog2(TRACK_LEN);
  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int AW = 4;

  localparam logic [CW-1:0] LAST_CAR   = CW'(NUM_CARS - 1);
  localparam logic [LW-1:0] LAST_LANE  = LW'(NUM_LANES - 1);
  localparam logic [PW-1:0] LAST_POS   = PW'(TRACK_LEN - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(FRAME_DIV - 1);
  localparam logic [AW-1:0] WIN_LAPS   = AW'(LAPS);

  typedef enum logic [2:0] {
    RST_SIG, IDLE, DRAW_BG, DRAW_CARS, WAIT_FRAME, CLEAR_CAR, UPDATE, WIN
  } state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       idx_reg, idx_next;
  logic [FW-1:0]       frame_cnt_reg, frame_cnt_next;
  logic [NUM_CARS-1:0] pend_fwd_reg, pend_fwd_next;
  logic [NUM_CARS-1:0] pend_l_reg, pend_l_next;
  logic [NUM_CARS-1:0] pend_r_reg, pend_r_next;
  logic [NUM_CARS-1:0] left_prev_reg, right_prev_reg;
  logic [LW-1:0]       lane_reg [NUM_CARS];
  logic [LW-1:0]       lane_next [NUM_CARS];
  logic [PW-1:0]       pos_reg [NUM_CARS];
  logic [PW-1:0]       pos_next [NUM_CARS];
  logic [AW-1:0]       lap_reg [NUM_CARS];
  logic [AW-1:0]       lap_next [NUM_CARS];
  logic                done_reg, done_next;
  logic [CW-1:0]       winner_reg, winner_next;

  logic                draw_bg_reg, draw_car_reg, clear_reg, resetsignal_reg;
  logic [CW-1:0]       car_sel_reg;
  logic [LW-1:0]       car_lane_reg;
  logic [PW-1:0]       car_pos_reg;

  logic [NUM_CARS-1:0] left_rise, right_rise;
  logic [NUM_CARS-1:0] pending;
  logic                capture_en;
  logic                wipe;

  // Button edges are only meaningful while a race is running; a press while
  // idle or after the finish must not leave a stale pending move behind.
  assign left_rise  = bus.left  & ~left_prev_reg;
  assign right_rise = bus.right & ~right_prev_reg;
  assign capture_en = (state_reg != RST_SIG) && (state_reg != IDLE) && (state_reg != WIN);

  // -------------------------------------------------------------------------
  // Per-car move candidates: what each car would become if it were the car
  // being updated this cycle. Only the selected car's result is committed.
  // -------------------------------------------------------------------------
  logic [LW-1:0]       mv_lane [NUM_CARS];
  logic [PW-1:0]       mv_pos  [NUM_CARS];
  logic [AW-1:0]       mv_lap  [NUM_CARS];
  logic [NUM_CARS-1:0] mv_finish;

  for (genvar gi = 0; gi < NUM_CARS; gi++) begin : g_car
    logic go_left, go_right, lap_wrap;

    // Opposite presses cancel; the track edges saturate rather than wrap.
    assign go_left  = pend_l_reg[gi] & ~pend_r_reg[gi] & (lane_reg[gi] != '0);
    assign go_right = pend_r_reg[gi] & ~pend_l_reg[gi] & (lane_reg[gi] != LAST_LANE);

    assign mv_lane[gi] = go_left  ? lane_reg[gi] - LW'(1) :
                         go_right ? lane_reg[gi] + LW'(1) : lane_reg[gi];

    assign lap_wrap   = pend_fwd_reg[gi] & (pos_reg[gi] == LAST_POS);
    assign mv_pos[gi] = !pend_fwd_reg[gi] ? pos_reg[gi] :
                        lap_wrap          ? '0 : pos_reg[gi] + PW'(1);
    assign mv_lap[gi] = lap_wrap ? lap_reg[gi] + AW'(1) : lap_reg[gi];

    assign mv_finish[gi] = lap_wrap & (mv_lap[gi] == WIN_LAPS);
  end

  function automatic logic [CW-1:0] lowest_set(input logic [NUM_CARS-1:0] vec);
    lowest_set = '0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = CW'(i);
    end
  endfunction

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    frame_cnt_next = frame_cnt_reg;
    pend_fwd_next  = pend_fwd_reg;
    pend_l_next    = pend_l_reg;
    pend_r_next    = pend_r_reg;
    lane_next      = lane_reg;
    pos_next       = pos_reg;
    lap_next       = lap_reg;
    done_next      = done_reg;
    winner_next    = winner_reg;
    pending        = '0;
    wipe           = 1'b0;

    if (capture_en) begin
      pend_l_next = pend_l_reg | left_rise;
      pend_r_next = pend_r_reg | right_rise;
    end

    case (state_reg)
      RST_SIG: state_next = IDLE;

      IDLE: begin
        if (bus.start) begin
          state_next = DRAW_BG;
          wipe       = 1'b1;
        end
      end

      // A handshake in flight always completes before an abort is honoured,
      // so the datapath never sees a request withdrawn mid-operation.
      DRAW_BG: begin
        if (bus.done_bg) begin
          state_next = bus.start ? DRAW_CARS : RST_SIG;
          idx_next   = '0;
        end
      end

      DRAW_CARS: begin
        if (bus.done_car) begin
          if (!bus.start) begin
            state_next = RST_SIG;
          end else if (idx_reg == LAST_CAR) begin
            state_next = done_reg ? WIN : WAIT_FRAME;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + CW'(1);
          end
        end
      end

      WAIT_FRAME: begin
        if (!bus.start) begin
          state_next = RST_SIG;
        end else if (bus.oneframe) begin
          if (frame_cnt_reg == LAST_FRAME) begin
            frame_cnt_next = '0;
            pend_fwd_next  = pend_fwd_reg | bus.straight;
          end else begin
            frame_cnt_next = frame_cnt_reg + FW'(1);
          end
          pending = pend_fwd_next | pend_l_next | pend_r_next;
          if (pending != '0) begin
            state_next = CLEAR_CAR;
            idx_next   = lowest_set(pending);
          end
        end
      end

      CLEAR_CAR: begin
        if (bus.done_clear) begin
          state_next = bus.start ? UPDATE : RST_SIG;
        end
      end

      UPDATE: begin
        for (int i = 0; i < NUM_CARS; i++) begin
          if (CW'(i) == idx_reg) begin
            lane_next[i]     = mv_lane[i];
            pos_next[i]      = mv_pos[i];
            lap_next[i]      = mv_lap[i];
            pend_fwd_next[i] = 1'b0;
            pend_l_next[i]   = 1'b0;
            pend_r_next[i]   = 1'b0;
            // Cars are updated in ascending order, so the first finisher of
            // a batch is also the lowest index among same-batch finishers.
            if (mv_finish[i] && !done_reg) begin
              done_next   = 1'b1;
              winner_next = CW'(i);
            end
          end
        end
        pending = pend_fwd_next | pend_l_next | pend_r_next;
        if (pending != '0) begin
          state_next = CLEAR_CAR;
          idx_next   = lowest_set(pending);
        end else begin
          state_next = DRAW_CARS;
          idx_next   = '0;
        end
      end

      WIN: begin
        if (!bus.start) state_next = RST_SIG;
      end

      default: state_next = RST_SIG;
    endcase

    // Entering the reset sequence leaves the same clean slate as the
    // external reset, so RST_SIG always presents identical outputs.
    if (state_next == RST_SIG) wipe = 1'b1;

    if (wipe) begin
      idx_next       = '0;
      frame_cnt_next = '0;
      pend_fwd_next  = '0;
      pend_l_next    = '0;
      pend_r_next    = '0;
      done_next      = 1'b0;
      winner_next    = '0;
      for (int i = 0; i < NUM_CARS; i++) begin
        lane_next[i] = '0;
        pos_next[i]  = '0;
        lap_next[i]  = '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= RST_SIG;
      idx_reg         <= '0;
      frame_cnt_reg   <= '0;
      pend_fwd_reg    <= '0;
      pend_l_reg      <= '0;
      pend_r_reg      <= '0;
      left_prev_reg   <= '0;
      right_prev_reg  <= '0;
      done_reg        <= 1'b0;
      winner_reg      <= '0;
      for (int i = 0; i < NUM_CARS; i++) begin
        lane_reg[i] <= '0;
        pos_reg[i]  <= '0;
        lap_reg[i]  <= '0;
      end
      draw_bg_reg     <= 1'b0;
      draw_car_reg    <= 1'b0;
      clear_reg       <= 1'b0;
      resetsignal_reg <= 1'b1;
      car_sel_reg     <= '0;
      car_lane_reg    <= '0;
      car_pos_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      frame_cnt_reg   <= frame_cnt_next;
      pend_fwd_reg    <= pend_fwd_next;
      pend_l_reg      <= pend_l_next;
      pend_r_reg      <= pend_r_next;
      left_prev_reg   <= bus.left;
      right_prev_reg  <= bus.right;
      done_reg        <= done_next;
      winner_reg      <= winner_next;
      lane_reg        <= lane_next;
      pos_reg         <= pos_next;
      lap_reg         <= lap_next;
      // Outputs track the state being entered, so they line up with the
      // state register on the same edge.
      draw_bg_reg     <= (state_next == DRAW_BG);
      draw_car_reg    <= (state_next == DRAW_CARS);
      clear_reg       <= (state_next == CLEAR_CAR);
      resetsignal_reg <= (state_next == RST_SIG);
      car_sel_reg     <= idx_next;
      car_lane_reg    <= lane_next[idx_next];
      car_pos_reg     <= pos_next[idx_next];
    end
  end

  assign bus.draw_bg     = draw_bg_reg;
  assign bus.draw_car    = draw_car_reg;
  assign bus.clear       = clear_reg;
  assign bus.resetsignal = resetsignal_reg;
  assign bus.car_sel     = car_sel_reg;
  assign bus.car_lane    = car_lane_reg;
  assign bus.car_pos     = car_pos_reg;
  assign bus.race_done   = done_reg;
  assign bus.winner      = winner_reg;

endmodule

// File: tb/tb_race_ctrl_multi.sv
module tb_race_ctrl_multi;
  localparam int NC    = 2;
  localparam int NL    = 4;
  localparam int TL    = 16;
  localparam int NLAPS = 3;
  localparam int FD    = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  race_ctrl_multi_if #(.NUM_CARS(NC), .NUM_LANES(NL), .TRACK_LEN(TL)) bus ();

  race_ctrl_multi #(
    .NUM_CARS(NC), .NUM_LANES(NL), .TRACK_LEN(TL), .LAPS(NLAPS), .FRAME_DIV(FD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: race state per car plus the pending-move bookkeeping.
  int            m_lane [NC];
  int            m_pos  [NC];
  int            m_lap  [NC];
  logic [NC-1:0] m_pf, m_pl, m_pr;
  int            m_fc;
  bit            m_done;
  int            m_win;
  int            batch_no = 0;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NC; i++) begin
      m_lane[i] = 0;
      m_pos[i]  = 0;
      m_lap[i]  = 0;
    end
    m_pf = '0; m_pl = '0; m_pr = '0;
    m_fc = 0; m_done = 0; m_win = 0;
  endfunction

  function automatic void m_move(input int i);
    if (m_pl[i] && !m_pr[i]) m_lane[i] = (m_lane[i] > 0) ? m_lane[i] - 1 : 0;
    if (m_pr[i] && !m_pl[i]) m_lane[i] = (m_lane[i] < NL - 1) ? m_lane[i] + 1 : NL - 1;
    if (m_pf[i]) begin
      m_pos[i] = (m_pos[i] + 1) % TL;
      if (m_pos[i] == 0) begin
        m_lap[i]++;
        if (m_lap[i] == NLAPS && !m_done) begin
          m_done = 1;
          m_win  = i;
        end
      end
    end
    m_pf[i] = 1'b0; m_pl[i] = 1'b0; m_pr[i] = 1'b0;
  endfunction

  function automatic bit req_now(input int kind);
    case (kind)
      0:       return bus.draw_bg;
      1:       return bus.draw_car;
      default: return bus.clear;
    endcase
  endfunction

  // Act as the datapath for one request: wait for it, check what it
  // addresses, hold a random number of cycles, then strobe completion.
  task automatic serve(input int kind, input int car);
    int n = 0;
    while (!req_now(kind) && n < 40) begin
      tick();
      n++;
    end
    if (!req_now(kind)) begin
      check(kind == 0 ? "bg_req_timeout" : kind == 1 ? "draw_req_timeout" : "clear_req_timeout", 0, 1);
      return;
    end
    if (kind == 1) begin
      check("draw_sel",  bus.car_sel,  car);
      check("draw_lane", bus.car_lane, m_lane[car]);
      check("draw_pos",  bus.car_pos,  m_pos[car]);
    end else if (kind == 2) begin
      check("clear_sel", bus.car_sel, car);
    end
    repeat ($urandom_range(0, 2)) tick();
    case (kind)
      0:       bus.done_bg    = 1'b1;
      1:       bus.done_car   = 1'b1;
      default: bus.done_clear = 1'b1;
    endcase
    tick();
    bus.done_bg = 1'b0; bus.done_car = 1'b0; bus.done_clear = 1'b0;
  endtask

  task automatic draw_all();
    for (int i = 0; i < NC; i++) serve(1, i);
  endtask

  task automatic startup();
    m_reset();
    serve(0, 0);
    draw_all();
  endtask

  // One video frame: optional button pulses, then the frame tick, then either
  // a full clear/update/redraw batch or a check that nothing moves.
  task automatic frame(input logic [NC-1:0] st, input logic [NC-1:0] lm, input logic [NC-1:0] rm);
    logic [NC-1:0] pend;
    bus.straight = st;
    if ((lm | rm) != '0) begin
      bus.left = lm; bus.right = rm;
      tick();
      bus.left = '0; bus.right = '0;
      tick();
      m_pl = m_pl | lm;
      m_pr = m_pr | rm;
    end
    bus.oneframe = 1'b1;
    tick();
    bus.oneframe = 1'b0;
    m_fc++;
    if (m_fc == FD) begin
      m_fc = 0;
      m_pf = m_pf | st;
    end
    pend = m_pf | m_pl | m_pr;
    if (pend == '0) begin
      tick(); tick();
      check("no_move", {bus.draw_car, bus.clear}, 0);
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (pend[i]) begin
          serve(2, i);
          m_move(i);
        end
      end
      draw_all();
      check("race_done", bus.race_done, m_done);
      if (m_done) check("winner", bus.winner, m_win);
      batch_no++;
      $display("batch %0d cars=%b lane=%0d,%0d pos=%0d,%0d lap=%0d,%0d done=%0d",
               batch_no, pend, m_lane[0], m_lane[1], m_pos[0], m_pos[1], m_lap[0], m_lap[1], m_done);
    end
  endtask

  task automatic rand_frame();
    logic [NC-1:0] st, lm, rm;
    for (int i = 0; i < NC; i++) begin
      st[i] = ($urandom_range(0, 3) != 0);
      lm[i] = ($urandom_range(0, 4) == 0);
      rm[i] = ($urandom_range(0, 4) == 0);
    end
    frame(st, lm, rm);
  endtask

  // After a win the sequencer must ignore buttons and frame ticks.
  task automatic win_phase();
    bus.straight = '1;
    bus.left = '1; bus.right = '1;
    tick();
    bus.left = '0; bus.right = '0;
    repeat (6) begin
      bus.oneframe = 1'b1; tick();
      bus.oneframe = 1'b0; tick();
    end
    check("win_quiet",  {bus.draw_bg, bus.draw_car, bus.clear}, 0);
    check("win_done",   bus.race_done, 1);
    check("win_winner", bus.winner, m_win);
    bus.straight = '0;
  endtask

  task automatic abort_restart();
    bus.start = 1'b0;
    tick();
    check("abort_resetsignal", bus.resetsignal, 1);
    check("abort_race_done",   bus.race_done, 0);
    tick();
    check("abort_idle", {bus.resetsignal, bus.draw_bg}, 0);
    bus.start = 1'b1;
    tick();
    startup();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b1;
    bus.straight = '0; bus.left = '0; bus.right = '0;
    bus.oneframe = 1'b0;
    bus.done_bg = 1'b0; bus.done_car = 1'b0; bus.done_clear = 1'b0;
    repeat (3) tick();
    check("rst_resetsignal", bus.resetsignal, 1);
    check("rst_requests", {bus.draw_bg, bus.draw_car, bus.clear}, 0);
    check("rst_race_done", bus.race_done, 0);
    check("rst_car_sel", bus.car_sel, 0);

    reset = 1'b0;
    check("rel_resetsignal", bus.resetsignal, 1);
    tick();
    check("idle_resetsignal", bus.resetsignal, 0);
    check("idle_draw_bg", bus.draw_bg, 0);
    tick();
    check("bg_request", bus.draw_bg, 1);
    startup();

    // Three ticks short of a forward step, then the fourth moves car 0.
    repeat (3) frame(2'b01, 2'b00, 2'b00);
    frame(2'b01, 2'b00, 2'b00);
    // Left at lane 0 saturates; right climbs to the last lane and saturates.
    frame(2'b00, 2'b10, 2'b00);
    repeat (5) frame(2'b00, 2'b00, 2'b10);
    // Opposing presses in one frame cancel.
    frame(2'b00, 2'b01, 2'b01);

    for (int f = 0; f < 1500 && !m_done; f++) rand_frame();
    check("race1_finished", bus.race_done, 1);
    win_phase();
    abort_restart();

    // Both cars always moving: same-batch finish, lowest index wins.
    for (int f = 0; f < 400 && !m_done; f++) frame(2'b11, 2'b00, 2'b00);
    check("race2_finished", bus.race_done, 1);
    check("race2_tie_winner", bus.winner, 0);
    win_phase();
    abort_restart();

    // Move the cars off their start spots, then reset during a clear.
    repeat (4) frame(2'b11, 2'b00, 2'b11);
    bus.straight = '0;
    bus.left = 2'b01; tick();
    bus.left = '0; tick();
    bus.oneframe = 1'b1; tick();
    bus.oneframe = 1'b0;
    check("pre_reset_clear", bus.clear, 1);
    #3 reset = 1'b1;
    #1;
    check("midrst_resetsignal", bus.resetsignal, 1);
    check("midrst_requests", {bus.draw_bg, bus.draw_car, bus.clear}, 0);
    check("midrst_lane", bus.car_lane, 0);
    check("midrst_pos", bus.car_pos, 0);
    #2 reset = 1'b0;
    tick();
    check("rel2_idle", {bus.resetsignal, bus.draw_bg}, 0);
    tick();
    check("rel2_bg_request", bus.draw_bg, 1);
    startup();
    repeat (12) rand_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
